// File: rtl/fifo_uart_tx.sv
// Purpose : pops bytes from a fall-through FIFO and sends each one as an 8-bit UART frame on tx.
// Latency : tx drops to START the cycle after the pop edge; frame = (1+8+parity+stop) * CLKS_PER_BIT cycles.
// Backpres: one pop per frame; pops only in IDLE with enable high, FIFO non-empty and reset low.
//
// Ports:
//   clock, reset  - system clock; synchronous active-high reset
//   enable        - gates the start of new frames; a frame in flight always finishes
//   fifo_empty    - FIFO empty flag
//   fifo_data     - FIFO head byte, valid while fifo_empty is low
//   fifo_deQ      - one-cycle pop strobe to the FIFO
//   tx            - registered serial line, idle high
//   busy          - high from the first START cycle through the last STOP cycle
//   done          - one-cycle pulse in the cycle after the final STOP cycle
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_deQ,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic [15:0] LAST_TICK  = 16'(CLKS_PER_BIT - 1);
    localparam bit          HAS_PARITY = (PARITY != 0);
    localparam bit          EVEN_PAR   = (PARITY == 2);
    // stop_idx value of the final stop bit (0 for one stop bit, 1 for two)
    localparam logic        LAST_STOP  = (STOP_BITS == 2);

    state_t      state;
    logic [15:0] tick;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        parity_bit;
    logic        stop_idx;
    logic        bit_end;

    // Combinational pop so the FIFO head is consumed on the same edge it is latched.
    assign fifo_deQ = (state == S_IDLE) & enable & ~fifo_empty & ~reset;
    assign bit_end  = (tick == LAST_TICK);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            tick       <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            parity_bit <= 1'b0;
            stop_idx   <= 1'b0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    tick <= '0;
                    if (fifo_deQ) begin
                        shift      <= fifo_data;
                        parity_bit <= EVEN_PAR ? ^fifo_data : ~^fifo_data;
                        bit_idx    <= '0;
                        stop_idx   <= 1'b0;
                        tx         <= 1'b0;
                        busy       <= 1'b1;
                        state      <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        tick  <= '0;
                        tx    <= shift[0];
                        state <= S_DATA;
                    end else begin
                        tick <= tick + 16'd1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        tick  <= '0;
                        shift <= shift >> 1;
                        if (bit_idx == 3'd7) begin
                            if (HAS_PARITY) begin
                                tx    <= parity_bit;
                                state <= S_PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= S_STOP;
                            end
                        end else begin
                            // next data bit is the one about to reach shift[0]
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shift[1];
                        end
                    end else begin
                        tick <= tick + 16'd1;
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        tick  <= '0;
                        tx    <= 1'b1;
                        state <= S_STOP;
                    end else begin
                        tick <= tick + 16'd1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        tick <= '0;
                        if (stop_idx == LAST_STOP) begin
                            tx    <= 1'b1;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            stop_idx <= ~stop_idx;
                        end
                    end else begin
                        tick <= tick + 16'd1;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Purpose : scoreboard bench for fifo_uart_tx; four instances cover no/odd/even parity and two stop bits.
// Latency : all instances use CLKS_PER_BIT = 4, so one bit lasts four cycles.
// Backpres: a behavioural FIFO per instance answers fifo_deQ; frames are decoded from tx by a monitor.
module tb_fifo_uart_tx;

    typedef struct {
        int          inst;
        logic [15:0] bits;
        int          nbits;
        bit          aborted;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic [3:0] fe, deq_w, tx_w, busy_w, done_w;
    logic [7:0] fd [4];

    logic [7:0] fmem [4][16];
    logic [3:0] fhead [4] = '{default: 4'd0};
    logic [3:0] ftail [4] = '{default: 4'd0};

    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    int   pop_q0[$];
    int   pops [4] = '{default: 0};
    int   last_pop [4] = '{default: -100};

    always #5 clock = ~clock;

    // instance 0: no parity, 1 stop; 1: odd; 2: even; 3: no parity, 2 stops
    fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) u_p0 (
        .clock(clock), .reset(reset), .enable(enable), .fifo_empty(fe[0]), .fifo_data(fd[0]),
        .fifo_deQ(deq_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));
    fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) u_odd (
        .clock(clock), .reset(reset), .enable(enable), .fifo_empty(fe[1]), .fifo_data(fd[1]),
        .fifo_deQ(deq_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));
    fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1)) u_even (
        .clock(clock), .reset(reset), .enable(enable), .fifo_empty(fe[2]), .fifo_data(fd[2]),
        .fifo_deQ(deq_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]));
    fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(2)) u_s2 (
        .clock(clock), .reset(reset), .enable(enable), .fifo_empty(fe[3]), .fifo_data(fd[3]),
        .fifo_deQ(deq_w[3]), .tx(tx_w[3]), .busy(busy_w[3]), .done(done_w[3]));

    function automatic int pmode(int i);
        return (i == 1) ? 1 : (i == 2) ? 2 : 0;
    endfunction

    function automatic int stops(int i);
        return (i == 3) ? 2 : 1;
    endfunction

    function automatic void chk_eq(string name, int act, int req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    // behavioural fall-through FIFO per instance
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            fe[i] = (fhead[i] == ftail[i]);
            fd[i] = fmem[i][fhead[i]];
        end
    end

    always @(posedge clock) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 4; i++)
            if (deq_w[i]) fhead[i] <= fhead[i] + 4'd1;
    end

    // Enqueue a byte and push the frame it must produce (LSB-first, parity bit given by hand).
    task automatic put(int i, logic [7:0] b, logic pbit, bit aborted);
        exp_t e;
        int   pos;
        e.inst    = i;
        e.aborted = aborted;
        e.bits    = '0;
        e.bits[8:1] = b;
        pos = 9;
        if (pmode(i) != 0) begin
            e.bits[pos] = pbit;
            pos++;
        end
        for (int s = 0; s < stops(i); s++) begin
            e.bits[pos] = 1'b1;
            pos++;
        end
        e.nbits = pos;
        fmem[i][ftail[i]] = b;
        ftail[i] = ftail[i] + 4'd1;
        exp_q.push_back(e);
    endtask

    // Monitor: records pops, decodes each frame from tx and compares it to the scoreboard.
    int         k [4] = '{default: 0};
    logic [15:0] fr [4];
    logic       cur [4];
    bit         unstable [4];
    logic [3:0] prev_busy = 4'd0;
    logic [3:0] prev_deq = 4'd0;
    logic       prev_reset = 1'b1;

    task automatic end_frame(int i);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk_eq("unexpected_frame", i, -1);
            return;
        end
        e = exp_q.pop_front();
        chk_eq("frame_owner", i, e.inst);
        if (prev_reset) begin
            chk_eq("aborted_frame", int'(e.aborted), 1);
        end else begin
            chk_eq("frame_not_aborted", int'(e.aborted), 0);
            chk_eq("frame_bits", int'(fr[i]), int'(e.bits));
            chk_eq("frame_len", k[i], e.nbits * 4);
            chk_eq("done_pulse", int'(done_w[i]), 1);
            chk_eq("bit_stable", int'(unstable[i]), 0);
            chk_eq("idle_high", int'(tx_w[i]), 1);
        end
    endtask

    always @(negedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (deq_w[i]) begin
                chk_eq("pop_nonempty", int'(fe[i]), 0);
                chk_eq("pop_not_back2back", int'(prev_deq[i]), 0);
                last_pop[i] = cyc + 1;
                pops[i]++;
                if (i == 0) pop_q0.push_back(cyc + 1);
            end
            if (busy_w[i] && !prev_busy[i]) begin
                chk_eq("busy_after_pop", cyc - last_pop[i], 0);
                chk_eq("start_low", int'(tx_w[i]), 0);
                k[i] = 0;
                fr[i] = '0;
                unstable[i] = 1'b0;
            end
            if (busy_w[i]) begin
                if (k[i] % 4 == 0) begin
                    cur[i] = tx_w[i];
                    if (k[i] / 4 < 16) fr[i][k[i] / 4] = tx_w[i];
                end else if (tx_w[i] != cur[i]) begin
                    unstable[i] = 1'b1;
                end
                k[i]++;
            end else if (prev_busy[i]) begin
                end_frame(i);
            end
        end
        prev_busy  = busy_w;
        prev_deq   = deq_w;
        prev_reset = reset;
    end

    task automatic sync();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_done(int i, string tag);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!done_w[i] && n < 200);
        chk_eq(tag, int'(done_w[i]), 1);
    endtask

    task automatic wait_busy(int i, string tag);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!busy_w[i] && n < 50);
        chk_eq(tag, int'(busy_w[i]), 1);
    endtask

    initial begin
        int p0;

        // reset state, and no pop while reset is high even with data queued
        repeat (3) @(posedge clock);
        #1;
        put(1, 8'hA5, 1'b1, 1'b0);
        #1;
        chk_eq("rst_tx", int'(tx_w), 15);
        chk_eq("rst_busy", int'(busy_w), 0);
        chk_eq("rst_done", int'(done_w), 0);
        chk_eq("rst_deq", int'(deq_w), 0);
        sync();
        reset = 1'b0;
        #1;
        chk_eq("pop_after_reset_release", int'(deq_w[1]), 1);
        wait_done(1, "odd_a5_done");

        // even parity vectors
        sync();
        put(2, 8'hA5, 1'b0, 1'b0);
        wait_done(2, "even_a5_done");
        sync();
        put(2, 8'h01, 1'b1, 1'b0);
        wait_done(2, "even_01_done");

        // single byte, no parity
        sync();
        p0 = pops[0];
        put(0, 8'hA5, 1'b0, 1'b0);
        wait_done(0, "single_done");
        chk_eq("done_40_after_pop", cyc - last_pop[0], 40);
        repeat (10) @(negedge clock);
        chk_eq("single_one_pop", pops[0] - p0, 1);
        chk_eq("single_fifo_empty", int'(fe[0]), 1);
        chk_eq("single_no_more_deq", int'(deq_w[0]), 0);

        // burst of three
        sync();
        pop_q0.delete();
        put(0, 8'h00, 1'b0, 1'b0);
        put(0, 8'hFF, 1'b0, 1'b0);
        put(0, 8'h3C, 1'b0, 1'b0);
        wait_done(0, "burst0_done");
        wait_done(0, "burst1_done");
        wait_done(0, "burst2_done");
        chk_eq("burst_pops", pop_q0.size(), 3);
        if (pop_q0.size() == 3) begin
            chk_eq("burst_gap01", pop_q0[1] - pop_q0[0], 41);
            chk_eq("burst_gap12", pop_q0[2] - pop_q0[1], 41);
        end
        chk_eq("burst_fifo_count", int'(ftail[0] - fhead[0]), 0);

        // two stop bits
        sync();
        put(3, 8'h96, 1'b0, 1'b0);
        wait_done(3, "stop2_done");

        // enable gating
        sync();
        put(0, 8'h5A, 1'b0, 1'b0);
        put(0, 8'hC3, 1'b0, 1'b0);
        wait_busy(0, "en_busy");
        repeat (10) @(posedge clock);
        #1;
        enable = 1'b0;
        p0 = pops[0];
        wait_done(0, "en_byte1_done");
        repeat (5) @(negedge clock);
        chk_eq("en_no_pop_while_low", pops[0] - p0, 0);
        chk_eq("en_deq_low", int'(deq_w[0]), 0);
        sync();
        enable = 1'b1;
        #1;
        chk_eq("en_pop_on_raise", int'(deq_w[0]), 1);
        wait_done(0, "en_byte2_done");

        // one-cycle reset during data bit 3
        sync();
        put(0, 8'h96, 1'b0, 1'b1);
        put(0, 8'h81, 1'b0, 1'b0);
        wait_busy(0, "rst_mid_busy");
        repeat (17) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        chk_eq("mid_rst_deq", int'(deq_w[0]), 0);
        sync();
        reset = 1'b0;
        #1;
        chk_eq("mid_rst_tx", int'(tx_w[0]), 1);
        chk_eq("mid_rst_busy", int'(busy_w[0]), 0);
        chk_eq("mid_rst_fresh_pop", int'(deq_w[0]), 1);
        wait_done(0, "after_rst_done");

        repeat (5) @(negedge clock);
        chk_eq("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got t=%0t expected finish", $time);
        $fatal(1);
    end

endmodule
